// File: rtl/io_pkg.sv
// Shared address map, read default and STAT/CTRL bit positions for the MMIO controller.
package io_pkg;

  localparam logic [15:0] IO_LED  = 16'hC000;
  localparam logic [15:0] IO_SW   = 16'hC001;
  localparam logic [15:0] IO_CNT  = 16'hC002;
  localparam logic [15:0] IO_CMP  = 16'hC003;
  localparam logic [15:0] IO_STAT = 16'hC004;
  localparam logic [15:0] IO_CTRL = 16'hC005;

  localparam logic [15:0] RD_DEFAULT = 16'hDEAD;

  localparam int STAT_MATCH    = 0;
  localparam int STAT_SWCHG    = 1;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_AUTO     = 1;
  localparam int CTRL_MATCH_IE = 2;
  localparam int CTRL_SWCHG_IE = 3;

  typedef enum logic [2:0] {
    SEL_LED  = 3'd0,
    SEL_SW   = 3'd1,
    SEL_CNT  = 3'd2,
    SEL_CMP  = 3'd3,
    SEL_STAT = 3'd4,
    SEL_CTRL = 3'd5,
    SEL_NONE = 3'd6
  } io_sel_e;

  // Full 16-bit decode; anything else (including the low 8K) is unmapped.
  function automatic io_sel_e io_decode(input logic [15:0] a);
    io_sel_e s;
    case (a)
      IO_LED:  s = SEL_LED;
      IO_SW:   s = SEL_SW;
      IO_CNT:  s = SEL_CNT;
      IO_CMP:  s = SEL_CMP;
      IO_STAT: s = SEL_STAT;
      IO_CTRL: s = SEL_CTRL;
      default: s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/io_timer.sv
// Prescaled 16-bit timer with compare: raises a one-cycle match pulse and requests
// an EN clear in one-shot mode.
module io_timer
  import io_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        autoreload,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic [15:0] wdata,
  output logic [15:0] cnt,
  output logic [15:0] cmp,
  output logic        match_set,
  output logic        oneshot_clr
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   cmp_q, cmp_d;
  logic          tick_s;
  logic          hit_s;

  // Prescaler wrap, compare hit and next timer state; a CNT write wins over the tick.
  always_comb begin
    tick_s      = en && (presc_q == PRE_LAST);
    hit_s       = (cnt_q == cmp_q);
    match_set   = tick_s && hit_s;
    oneshot_clr = match_set && !autoreload;

    if (cnt_we || ctrl_we || !en || tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (cnt_we) begin
      cnt_d = wdata;
    end else if (tick_s && !hit_s) begin
      cnt_d = cnt_q + 16'd1;
    end else if (match_set && autoreload) begin
      cnt_d = 16'h0000;
    end else begin
      cnt_d = cnt_q;
    end

    if (cmp_we) begin
      cmp_d = wdata;
    end else begin
      cmp_d = cmp_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= 16'h0000;
      cmp_q   <= 16'hFFFF;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
    end
  end

  assign cnt = cnt_q;
  assign cmp = cmp_q;

endmodule

// File: rtl/mmio_ctrl.sv
// CPU-facing MMIO block at 0xC000-0xC005: LEDs, synchronised switches, timer,
// sticky status and control, with a same-cycle read mux.
module mmio_ctrl
  import io_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int NUM_SW   = 10,
  parameter int NUM_LED  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        addr,
  input  logic               re,
  input  logic               we,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata,
  input  logic [NUM_SW-1:0]  sw,
  output logic [NUM_LED-1:0] led,
  output logic               irq
);

  io_sel_e            sel_s;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [NUM_SW-1:0]  sync1_q, sync1_d;
  logic [NUM_SW-1:0]  sync2_q, sync2_d;
  logic [NUM_SW-1:0]  sync3_q, sync3_d;
  logic [1:0]         stat_q, stat_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               cnt_we_s, cmp_we_s, ctrl_we_s, stat_we_s, led_we_s;
  logic               match_set_s, oneshot_clr_s;
  logic [15:0]        cnt_s, cmp_s;

  assign sel_s = io_decode(addr);

  // Per-register write strobes.
  always_comb begin
    led_we_s  = we && (sel_s == SEL_LED);
    cnt_we_s  = we && (sel_s == SEL_CNT);
    cmp_we_s  = we && (sel_s == SEL_CMP);
    stat_we_s = we && (sel_s == SEL_STAT);
    ctrl_we_s = we && (sel_s == SEL_CTRL);
  end

  io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (ctrl_q[CTRL_EN]),
    .autoreload  (ctrl_q[CTRL_AUTO]),
    .cnt_we      (cnt_we_s),
    .cmp_we      (cmp_we_s),
    .ctrl_we     (ctrl_we_s),
    .wdata       (wdata),
    .cnt         (cnt_s),
    .cmp         (cmp_s),
    .match_set   (match_set_s),
    .oneshot_clr (oneshot_clr_s)
  );

  // Next state for LEDs, switch synchroniser, sticky status and control.
  always_comb begin
    sync1_d = sw;
    sync2_d = sync1_q;
    sync3_d = sync2_q;

    if (led_we_s) begin
      led_d = wdata[NUM_LED-1:0];
    end else begin
      led_d = led_q;
    end

    // Hardware sets are OR-ed in after the W1C so a coincident set wins.
    if (stat_we_s) begin
      stat_d = stat_q & ~wdata[1:0];
    end else begin
      stat_d = stat_q;
    end
    if (match_set_s) begin
      stat_d[STAT_MATCH] = 1'b1;
    end else begin
      stat_d[STAT_MATCH] = stat_d[STAT_MATCH];
    end
    if (sync2_q != sync3_q) begin
      stat_d[STAT_SWCHG] = 1'b1;
    end else begin
      stat_d[STAT_SWCHG] = stat_d[STAT_SWCHG];
    end

    if (ctrl_we_s) begin
      ctrl_d = wdata[3:0];
    end else if (oneshot_clr_s) begin
      ctrl_d          = ctrl_q;
      ctrl_d[CTRL_EN] = 1'b0;
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Top-level register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      stat_q  <= 2'b00;
      ctrl_q  <= 4'h0;
    end else begin
      led_q   <= led_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      stat_q  <= stat_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Same-cycle read mux; shows pre-write contents when re and we coincide.
  always_comb begin
    rdata = RD_DEFAULT;
    if (re) begin
      case (sel_s)
        SEL_LED: begin
          rdata                = 16'h0000;
          rdata[NUM_LED-1:0]   = led_q;
        end
        SEL_SW: begin
          rdata                = 16'h0000;
          rdata[NUM_SW-1:0]    = sync2_q;
        end
        SEL_CNT:  rdata = cnt_s;
        SEL_CMP:  rdata = cmp_s;
        SEL_STAT: rdata = {14'h0000, stat_q};
        SEL_CTRL: rdata = {12'h000, ctrl_q};
        default:  rdata = RD_DEFAULT;
      endcase
    end else begin
      rdata = RD_DEFAULT;
    end
  end

  assign led = led_q;
  assign irq = (stat_q[STAT_MATCH] & ctrl_q[CTRL_MATCH_IE]) |
               (stat_q[STAT_SWCHG] & ctrl_q[CTRL_SWCHG_IE]);

endmodule
